// File: rtl/eight_div_module_pkg.sv
// Shared arithmetic definitions for the divider and its multiplier neighbour.
// Holds the default operand width, FSM state encoding and divide-by-zero result.
package eight_div_module_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Quotient reported when the divisor is zero (all ones at the default width).
    localparam logic [DefaultWidth-1:0] DivZeroQuot = '1;

endpackage

// File: rtl/div_step_module.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only if it did not go negative.
module div_step_module
    import eight_div_module_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below the divisor, so WIDTH bits hold it and
    // the extra top bit of the trial difference acts purely as the borrow flag.
    always_comb begin
        shifted = {r, q_msb};
        trial   = shifted - {1'b0, d};
        q_bit   = ~trial[WIDTH];
        r_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/eight_div_module.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held
// until the next accepted start, single-cycle done strobe.
module eight_div_module
    import eight_div_module_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic             step_bit;

    div_step_module #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .r_next (step_r),
        .q_bit  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (b == '0) begin
                        // Zero divisor bypasses iteration entirely.
                        state_d = StDone;
                        quot_d  = '1;
                        rem_d   = a;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = StCalc;
                        q_d     = a;
                        d_d     = b;
                        r_d     = '0;
                        cnt_d   = '0;
                    end
                end
            end
            StCalc: begin
                r_d   = step_r;
                q_d   = {q_q[WIDTH-2:0], step_bit};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    quot_d  = {q_q[WIDTH-2:0], step_bit};
                    rem_d   = step_r;
                    dbz_d   = 1'b0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule
